// File: rtl/mul_pkg.sv
// Shared definitions for the sequential signed 32x32 multiplier.
//   MUL_WIDTH   operand width
//   MUL_ITERS   radix-4 Booth digits per operand (one per RUN cycle)
//   MUL_PP_W    partial-product / upper-accumulator width (operand + 2 guard bits)
//   mul_state_e control FSM states
package mul_pkg;

    localparam int MUL_WIDTH = 32;
    localparam int MUL_ITERS = 16;
    localparam int MUL_PP_W  = MUL_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul_32_seq_if.sv
// Request/result bundle of the sequential multiplier.
//   start          request a multiply (honoured only while idle)
//   a_multiplicand signed multiplicand, captured with start
//   b_multiplier   signed multiplier, captured with start
//   busy           high while a multiply is in progress or completing
//   done           one-cycle pulse, c_product valid
//   c_product      signed product, {HI[63:32], LO[31:0]}
// master = requester, slave = multiplier.
interface mul_32_seq_if;
    import mul_pkg::*;

    logic                     start;
    logic [MUL_WIDTH-1:0]     a_multiplicand;
    logic [MUL_WIDTH-1:0]     b_multiplier;
    logic                     busy;
    logic                     done;
    logic [2*MUL_WIDTH-1:0]   c_product;

    modport master (
        output start, a_multiplicand, b_multiplier,
        input  busy, done, c_product
    );

    modport slave (
        input  start, a_multiplicand, b_multiplier,
        output busy, done, c_product
    );

endinterface

// File: rtl/booth_r4_sel.sv
// Radix-4 Booth partial-product selector (combinational).
//   bits   {b[i+1], b[i], b[i-1]} multiplier triplet
//   mcand  signed multiplicand
//   pp     digit * mcand, digit in {-2,-1,0,+1,+2}, sign-extended to 34 bits
module booth_r4_sel
    import mul_pkg::*;
(
    input  logic [2:0]           bits,
    input  logic [MUL_WIDTH-1:0] mcand,
    output logic [MUL_PP_W-1:0]  pp
);

    logic [MUL_PP_W-1:0] ext;

    // Two guard bits: +/-2 * (-2^31) still fits as a signed 34-bit value.
    assign ext = {{2{mcand[MUL_WIDTH-1]}}, mcand};

    always_comb begin
        pp = '0;
        unique case (bits)
            3'b001, 3'b010: pp = ext;
            3'b011:         pp = ext << 1;
            3'b100:         pp = -(ext << 1);
            3'b101, 3'b110: pp = -ext;
            default:        pp = '0;      // 000 / 111: digit 0
        endcase
    end

endmodule

// File: rtl/mul_32_seq.sv
// Sequential signed 32x32 -> 64 multiplier, radix-4 Booth, one digit per cycle.
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   mbus     mul_32_seq_if slave: start/operands in, busy/done/c_product out
// Timing: start sampled in IDLE at edge N; RUN occupies the 16 cycles after
// edges N..N+15; the DONE cycle follows edge N+16 (done pulse, product valid);
// the block is back in IDLE after edge N+17, giving one result per 18 cycles.
module mul_32_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
)(
    input  logic          clk,
    input  logic          reset_n,
    mul_32_seq_if.slave   mbus
);

    mul_state_e         state_q, state_d;
    logic [3:0]         cnt_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH+1:0]   acc_q;       // upper half of the shifting product pair
    logic [WIDTH-1:0]   mq_q;        // multiplier, refilled from the bottom of acc
    logic               q_m1_q;      // implicit bit below the current digit
    logic [2*WIDTH-1:0] prod_q;

    logic [WIDTH+1:0]   pp;
    logic [WIDTH+1:0]   acc_sum;
    logic [WIDTH+1:0]   acc_shift;
    logic [WIDTH-1:0]   mq_shift;
    logic               last_iter;
    logic               busy, done;

    booth_r4_sel u_sel (
        .bits  ({mq_q[1:0], q_m1_q}),
        .mcand (mcand_q),
        .pp    (pp)
    );

    // Add the digit product, then arithmetic shift {acc, mq} right by 2.
    assign acc_sum   = acc_q + pp;
    assign acc_shift = {{2{acc_sum[WIDTH+1]}}, acc_sum[WIDTH+1:2]};
    assign mq_shift  = {acc_sum[1:0], mq_q[WIDTH-1:2]};
    assign last_iter = (cnt_q == 4'(MUL_ITERS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: if (mbus.start) state_d = RUN;
            RUN: begin
                busy = 1'b1;
                if (last_iter) state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            q_m1_q  <= 1'b0;
            prod_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (mbus.start) begin
                    cnt_q   <= '0;
                    mcand_q <= mbus.a_multiplicand;
                    mq_q    <= mbus.b_multiplier;
                    q_m1_q  <= 1'b0;
                    acc_q   <= '0;
                end
                RUN: begin
                    cnt_q  <= cnt_q + 4'd1;
                    acc_q  <= acc_shift;
                    mq_q   <= mq_shift;
                    q_m1_q <= mq_q[1];
                    // After the 16th shift the full product sits in {acc[31:0], mq}.
                    if (last_iter) prod_q <= {acc_shift[WIDTH-1:0], mq_shift};
                end
                default: ;
            endcase
        end
    end

    assign mbus.busy      = busy;
    assign mbus.done      = done;
    assign mbus.c_product = prod_q;

endmodule

// File: tb/tb_mul_32_seq.sv
module tb_mul_32_seq;

    logic clk;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;
    logic [63:0] last_prod;

    mul_32_seq_if bus();

    mul_32_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mbus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at negedge 18, DUT idle.
    // noisy: toggle start and scramble operands while the operation runs.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input bit noisy, input string tag);
        int early;
        int held_bad;
        logic d17, d18, b18;
        logic [63:0] p17;
        early = 0; held_bad = 0;
        bus.start = 1'b1;
        bus.a_multiplicand = a;
        bus.b_multiplier   = b;
        @(posedge clk); #1;
        if (!noisy) bus.start = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k < 17) begin
                if (bus.done !== 1'b0) early++;
                if (bus.c_product !== last_prod) held_bad++;
                if (bus.busy !== 1'b1) early++;
            end
            if (k == 17) begin d17 = bus.done; p17 = bus.c_product; end
            if (k == 18) begin d18 = bus.done; b18 = bus.busy; end
            if (noisy && k < 17) begin
                bus.start          = 1'($urandom);
                bus.a_multiplicand = $urandom;
                bus.b_multiplier   = $urandom;
            end
            if (k == 17) bus.start = 1'b0;
        end
        chk({tag, "_run_flags"}, 64'(early), 64'd0);
        chk({tag, "_hold"}, 64'(held_bad), 64'd0);
        chk({tag, "_done_at_17"}, {63'd0, d17}, 64'd1);
        chk({tag, "_product"}, p17, exp);
        chk({tag, "_done_width"}, {62'd0, d18, b18}, 64'd0);
        last_prod = exp;
    endtask

    initial begin
        int bad;
        logic [31:0] ra, rb;

        tbl[0] = '{32'd7,          32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
        tbl[1] = '{32'h8000_0000,  32'h8000_0000, 64'h4000_0000_0000_0000};
        tbl[2] = '{32'h8000_0000,  32'd1,         64'hFFFF_FFFF_8000_0000};
        tbl[3] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        tbl[4] = '{32'h0001_0000,  32'h0001_0000, 64'h0000_0001_0000_0000};
        tbl[5] = '{32'h7FFF_FFFF,  32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
        tbl[6] = '{32'hFFFF_FFFF,  32'h8000_0000, 64'h0000_0000_8000_0000};
        tbl[7] = '{32'h0000_0000,  32'hDEAD_BEEF, 64'h0000_0000_0000_0000};
        tbl[8] = '{32'h7FFF_FFFF,  32'h8000_0000, 64'hC000_0000_8000_0000};
        tbl[9] = '{32'd12345,      32'd6789,      64'd83810205};

        reset_n = 1'b0;
        bus.start = 1'b0;
        bus.a_multiplicand = '0;
        bus.b_multiplier   = '0;
        last_prod = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {63'd0, bus.busy}, 64'd0);
        chk("reset_done", {63'd0, bus.done}, 64'd0);
        chk("reset_product", bus.c_product, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            run_op(tbl[i].a, tbl[i].b, tbl[i].p, i[0], $sformatf("vec%0d", i));

        // Start held high: one result every 18 cycles, busy-time starts ignored.
        bad = 0;
        bus.start = 1'b1;
        bus.a_multiplicand = 32'h0001_0000;
        bus.b_multiplier   = 32'h0001_0000;
        for (int k = 1; k <= 72; k++) begin
            @(negedge clk);
            if (bus.done !== ((k % 18) == 17)) bad++;
            if (bus.done === 1'b1)
                chk($sformatf("stream_product_k%0d", k), bus.c_product, 64'h0000_0001_0000_0000);
            if (k == 71) bus.start = 1'b0;
        end
        chk("stream_done_pattern", 64'(bad), 64'd0);
        last_prod = 64'h0000_0001_0000_0000;
        @(negedge clk);

        // Reset in RUN cycle 8: immediate clear, no late done pulse.
        bus.start = 1'b1;
        bus.a_multiplicand = 32'h0001_2345;
        bus.b_multiplier   = 32'hFFFF_FFB3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort_busy", {63'd0, bus.busy}, 64'd0);
        chk("abort_done", {63'd0, bus.done}, 64'd0);
        chk("abort_product", bus.c_product, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        last_prod = '0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        chk("abort_no_done", 64'(bad), 64'd0);
        run_op(32'h0001_2345, 32'hFFFF_FFB3, ref_mul(32'h0001_2345, 32'hFFFF_FFB3), 1'b0, "post_reset");

        for (int i = 0; i < 2500; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 40 == 0) ra = 32'h8000_0000;
            if (i % 60 == 0) rb = 32'h8000_0000;
            if (i % 70 == 0) rb = 32'h7FFF_FFFF;
            run_op(ra, rb, ref_mul(ra, rb), (i % 4) == 3, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
